// File: rtl/frame_loader_if.sv
// Row-writer / scanner bus for the LED-matrix frame loader.
//   row_data      writer -> loader   pixel word for the current row (bit c = column c)
//   row_valid     writer -> loader   row_data is valid
//   row_ready     loader -> writer   loader accepts a row this cycle
//   restart       writer -> loader   discard partial/pending frame, row index back to 0
//   frame_done    scanner -> loader  one-cycle pulse at the end of a full scan
//   next          loader -> scanner  displayed frame, row r at next[r*COLS +: COLS]
//   frame_pending loader -> writer   a complete frame is waiting for a swap
//   swap_count    loader -> writer   number of swaps performed, wraps 255 -> 0
// The master modport is the writer/scanner side, slave is the loader.
interface frame_loader_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic [COLS-1:0]      row_data;
  logic                 row_valid;
  logic                 row_ready;
  logic                 restart;
  logic                 frame_done;
  logic [ROWS*COLS-1:0] next;
  logic                 frame_pending;
  logic [7:0]           swap_count;

  modport master (
    output row_data, row_valid, restart, frame_done,
    input  row_ready, next, frame_pending, swap_count
  );

  modport slave (
    input  row_data, row_valid, restart, frame_done,
    output row_ready, next, frame_pending, swap_count
  );
endinterface

// File: rtl/frame_loader.sv
// Writer side of the LED-matrix scan interface. Rows arrive one per
// valid/ready transfer into a back buffer; the completed frame is copied to
// the displayed `next` bus only at a swap, so the scanner never sees a
// half-written frame.
// Ports:
//   clk    in  system clock, all logic on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    frame_loader_if.slave (row handshake, restart, frame_done, next,
//          frame_pending, swap_count)
// SWAP_ON_SYNC=1 holds a complete frame until the scanner's frame_done;
// SWAP_ON_SYNC=0 swaps on the same edge that lands the last row.
module frame_loader #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter bit SWAP_ON_SYNC = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_loader_if.slave bus
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          row_idx_q, row_idx_d;
  logic [ROWS-1:0][COLS-1:0] back_q, back_d;
  logic [ROWS*COLS-1:0]      next_q, next_d;
  logic [7:0]                swap_count_q, swap_count_d;

  logic accept;
  logic last_row;
  logic swap;
  logic row_ready;
  logic frame_pending;

  // Event decode. restart outranks everything, so it masks both the row
  // write and a frame_done-triggered swap on the same edge.
  always_comb begin
    accept   = (state_q == FILL) && bus.row_valid && !bus.restart;
    last_row = (row_idx_q == LAST_ROW);
    if (SWAP_ON_SYNC) begin
      swap = (state_q == WAIT_SWAP) && bus.frame_done && !bus.restart;
    end else begin
      swap = accept && last_row;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      row_idx_q    <= '0;
      back_q       <= '0;
      next_q       <= '0;
      swap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      back_q       <= back_d;
      next_q       <= next_d;
      swap_count_q <= swap_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    if (bus.restart) begin
      state_d   = FILL;
      row_idx_d = '0;
    end else if (state_q == WAIT_SWAP) begin
      if (bus.frame_done) begin
        state_d = FILL;
      end
    end else if (accept) begin
      if (last_row) begin
        row_idx_d = '0;
        if (SWAP_ON_SYNC) begin
          state_d = WAIT_SWAP;
        end
      end else begin
        row_idx_d = row_idx_q + 1'b1;
      end
    end
  end

  // One write port per row; rows are never cleared, only overwritten.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign back_d[gi] = (accept && (row_idx_q == IDX_W'(gi))) ? bus.row_data : back_q[gi];
  end

  // Copying back_d (not back_q) lets the immediate-swap mode include the row
  // written on the swap edge; in WAIT_SWAP no write happens, so both agree.
  always_comb begin
    next_d       = swap ? back_d : next_q;
    swap_count_d = swap ? swap_count_q + 8'd1 : swap_count_q;
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    row_ready     = (state_q == FILL);
    frame_pending = (state_q == WAIT_SWAP);
  end

  assign bus.row_ready     = row_ready;
  assign bus.frame_pending = frame_pending;
  assign bus.next          = next_q;
  assign bus.swap_count    = swap_count_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: dut1 swaps on frame_done, dut0 swaps on the last row.
module tb_frame_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_loader_if #(.ROWS(8), .COLS(8)) bus0 ();
  frame_loader_if #(.ROWS(8), .COLS(8)) bus1 ();

  frame_loader #(.ROWS(8), .COLS(8), .SWAP_ON_SYNC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  frame_loader #(.ROWS(8), .COLS(8), .SWAP_ON_SYNC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Per-DUT drive and observe variables, index = DUT number
  logic [7:0]  rd [2];
  logic        rv [2];
  logic        rs [2];
  logic        fd [2];
  logic [63:0] nx [2];
  logic        rr [2];
  logic        fp [2];
  logic [7:0]  sc [2];

  assign bus0.row_data = rd[0];  assign bus1.row_data = rd[1];
  assign bus0.row_valid = rv[0]; assign bus1.row_valid = rv[1];
  assign bus0.restart = rs[0];   assign bus1.restart = rs[1];
  assign bus0.frame_done = fd[0]; assign bus1.frame_done = fd[1];
  assign nx[0] = bus0.next;          assign nx[1] = bus1.next;
  assign rr[0] = bus0.row_ready;     assign rr[1] = bus1.row_ready;
  assign fp[0] = bus0.frame_pending; assign fp[1] = bus1.frame_pending;
  assign sc[0] = bus0.swap_count;    assign sc[1] = bus1.swap_count;

  // Reference model: what the scanner should currently see and how many swaps
  logic [63:0] exp_next [2];
  int          exp_cnt  [2];

  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] pack8(input logic [7:0] f [8]);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) v[r*8 +: 8] = f[r];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one row and hold it until accepted (bounded).
  task automatic push_row(input int d, input logic [7:0] v);
    int n;
    n = 0;
    rd[d] = v;
    rv[d] = 1'b1;
    while (!rr[d] && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rr[d] !== 1'b1) begin
      errors++;
      $display("FAIL push_row dut%0d: row_ready=%b, required 1 within 20 cycles", d, rr[d]);
    end
    tick();
    rv[d] = 1'b0;
  endtask

  task automatic push_frame(input int d, input logic [7:0] f [8]);
    for (int r = 0; r < 8; r++) push_row(d, f[r]);
  endtask

  task automatic pulse_done(input int d);
    fd[d] = 1'b1;
    tick();
    fd[d] = 1'b0;
  endtask

  task automatic rand_frame(output logic [7:0] f [8]);
    for (int r = 0; r < 8; r++) f[r] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d] = '0; rv[d] = 1'b0; rs[d] = 1'b0; fd[d] = 1'b0;
      exp_next[d] = '0; exp_cnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (nx[d] !== 64'h0) begin errors++; $display("FAIL reset_next dut%0d: got %h, required 0", d, nx[d]); end
      checks++;
      if (sc[d] !== 8'd0) begin errors++; $display("FAIL reset_count dut%0d: got %0d, required 0", d, sc[d]); end
      checks++;
      if (fp[d] !== 1'b0) begin errors++; $display("FAIL reset_pending dut%0d: got %b, required 0", d, fp[d]); end
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rr[d] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b, required 1", d, rr[d]); end
    end
  endtask

  task automatic test_full_load();
    logic [7:0] f [8];
    for (int it = 0; it < 3; it++) begin
      if (it == 0) for (int r = 0; r < 8; r++) f[r] = 8'h01 << r;
      else rand_frame(f);
      push_frame(1, f);
      checks++;
      if (fp[1] !== 1'b1 || rr[1] !== 1'b0) begin
        errors++; $display("FAIL full_pending it%0d: pending=%b ready=%b, required 1/0", it, fp[1], rr[1]);
      end
      checks++;
      if (nx[1] !== exp_next[1]) begin
        errors++; $display("FAIL full_next_held it%0d: got %h, required %h", it, nx[1], exp_next[1]);
      end
      pulse_done(1);
      exp_next[1] = pack8(f);
      exp_cnt[1]  = (exp_cnt[1] + 1) % 256;
      if (it == 0) begin
        checks++;
        if (nx[1] !== 64'h8040201008040201) begin
          errors++; $display("FAIL full_pattern: got %h, required 8040201008040201", nx[1]);
        end
      end
      checks++;
      if (nx[1] !== exp_next[1]) begin
        errors++; $display("FAIL full_swap it%0d: got %h, required %h", it, nx[1], exp_next[1]);
      end
      checks++;
      if (sc[1] !== 8'(exp_cnt[1]) || rr[1] !== 1'b1 || fp[1] !== 1'b0) begin
        errors++; $display("FAIL full_after it%0d: count=%0d ready=%b pending=%b, required %0d/1/0",
                           it, sc[1], rr[1], fp[1], exp_cnt[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] fb [8];
    logic [7:0] fc [8];
    rand_frame(fb);
    rand_frame(fc);
    fc[0] = 8'hFF;
    push_frame(1, fb);
    rd[1] = 8'hFF;
    rv[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rr[1] !== 1'b0 || nx[1] !== exp_next[1]) begin
        errors++; $display("FAIL bp_hold cyc%0d: ready=%b next=%h, required 0/%h", i, rr[1], nx[1], exp_next[1]);
      end
    end
    fd[1] = 1'b1;
    tick();
    fd[1] = 1'b0;
    exp_next[1] = pack8(fb);
    exp_cnt[1]  = (exp_cnt[1] + 1) % 256;
    checks++;
    if (nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1])) begin
      errors++; $display("FAIL bp_swap: next=%h count=%0d, required %h/%0d", nx[1], sc[1], exp_next[1], exp_cnt[1]);
    end
    tick();  // held 8'hFF is accepted as row 0 now
    rv[1] = 1'b0;
    for (int r = 1; r < 8; r++) push_row(1, fc[r]);
    checks++;
    if (fp[1] !== 1'b1) begin errors++; $display("FAIL bp_pending: got %b, required 1", fp[1]); end
    pulse_done(1);
    exp_next[1] = pack8(fc);
    exp_cnt[1]  = (exp_cnt[1] + 1) % 256;
    checks++;
    if (nx[1] !== exp_next[1]) begin
      errors++; $display("FAIL bp_row0: got %h, required %h", nx[1], exp_next[1]);
    end
  endtask

  task automatic test_restart();
    logic [7:0] f [8];
    for (int r = 0; r < 3; r++) push_row(1, 8'($urandom));
    rd[1] = 8'hA5; rv[1] = 1'b1; rs[1] = 1'b1;
    tick();
    rs[1] = 1'b0; rv[1] = 1'b0;
    checks++;
    if (rr[1] !== 1'b1 || fp[1] !== 1'b0 || nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1])) begin
      errors++; $display("FAIL restart_state: ready=%b pending=%b next=%h count=%0d", rr[1], fp[1], nx[1], sc[1]);
    end
    rand_frame(f);
    for (int r = 0; r < 7; r++) push_row(1, f[r]);
    checks++;
    if (fp[1] !== 1'b0) begin errors++; $display("FAIL restart_idx: pending=%b after 7 rows, required 0", fp[1]); end
    push_row(1, f[7]);
    pulse_done(1);
    exp_next[1] = pack8(f);
    exp_cnt[1]  = (exp_cnt[1] + 1) % 256;
    checks++;
    if (nx[1] !== exp_next[1]) begin errors++; $display("FAIL restart_new: got %h, required %h", nx[1], exp_next[1]); end
    // restart outranks frame_done in WAIT_SWAP
    rand_frame(f);
    push_frame(1, f);
    rs[1] = 1'b1; fd[1] = 1'b1;
    tick();
    rs[1] = 1'b0; fd[1] = 1'b0;
    checks++;
    if (nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1]) || fp[1] !== 1'b0) begin
      errors++; $display("FAIL restart_prio: next=%h count=%0d pending=%b, required %h/%0d/0",
                         nx[1], sc[1], fp[1], exp_next[1], exp_cnt[1]);
    end
    rand_frame(f);
    push_frame(1, f);
    pulse_done(1);
    exp_next[1] = pack8(f);
    exp_cnt[1]  = (exp_cnt[1] + 1) % 256;
    checks++;
    if (nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1])) begin
      errors++; $display("FAIL restart_reload: next=%h count=%0d, required %h/%0d", nx[1], sc[1], exp_next[1], exp_cnt[1]);
    end
  endtask

  task automatic test_early_sync();
    logic [7:0] f [8];
    rand_frame(f);
    pulse_done(1);
    checks++;
    if (nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1])) begin
      errors++; $display("FAIL early_empty: next=%h count=%0d, required %h/%0d", nx[1], sc[1], exp_next[1], exp_cnt[1]);
    end
    for (int r = 0; r < 4; r++) push_row(1, f[r]);
    pulse_done(1);
    checks++;
    if (nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1])) begin
      errors++; $display("FAIL early_partial: next=%h count=%0d, required %h/%0d", nx[1], sc[1], exp_next[1], exp_cnt[1]);
    end
    for (int r = 4; r < 8; r++) push_row(1, f[r]);
    repeat (5) tick();
    checks++;
    if (nx[1] !== exp_next[1] || fp[1] !== 1'b1) begin
      errors++; $display("FAIL early_noqueue: next=%h pending=%b, required %h/1", nx[1], fp[1], exp_next[1]);
    end
    pulse_done(1);
    exp_next[1] = pack8(f);
    exp_cnt[1]  = (exp_cnt[1] + 1) % 256;
    checks++;
    if (nx[1] !== exp_next[1]) begin errors++; $display("FAIL early_swap: got %h, required %h", nx[1], exp_next[1]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f [8];
    for (int k = 0; k < 256; k++) begin
      rand_frame(f);
      rv[0] = 1'b1;
      for (int r = 0; r < 8; r++) begin
        rd[0] = f[r];
        tick();
        if (r == 6 && (k % 64) == 0) begin
          checks++;
          if (nx[0] !== exp_next[0] || rr[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_partial frame%0d: next=%h ready=%b, required %h/1", k, nx[0], rr[0], exp_next[0]);
          end
        end
      end
      exp_next[0] = pack8(f);
      exp_cnt[0]  = (exp_cnt[0] + 1) % 256;
      checks++;
      if (nx[0] !== exp_next[0] || sc[0] !== 8'(exp_cnt[0]) || fp[0] !== 1'b0) begin
        errors++; $display("FAIL b2b frame%0d: next=%h count=%0d pending=%b, required %h/%0d/0",
                           k, nx[0], sc[0], fp[0], exp_next[0], exp_cnt[0]);
      end
    end
    rv[0] = 1'b0;
    checks++;
    if (sc[0] !== 8'd0) begin errors++; $display("FAIL b2b_wrap: count=%0d, required 0", sc[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] f [8];
    for (int r = 0; r < 3; r++) push_row(1, 8'($urandom));
    rd[1] = 8'($urandom);
    rv[1] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_next[d] = '0;
      exp_cnt[d]  = 0;
      checks++;
      if (nx[d] !== 64'h0 || sc[d] !== 8'd0 || fp[d] !== 1'b0) begin
        errors++; $display("FAIL reset_mid dut%0d: next=%h count=%0d pending=%b, required 0/0/0", d, nx[d], sc[d], fp[d]);
      end
    end
    rv[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (rr[1] !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b, required 1", rr[1]); end
    rand_frame(f);
    for (int r = 0; r < 5; r++) push_row(1, f[r]);
    checks++;
    if (fp[1] !== 1'b0) begin errors++; $display("FAIL reset_mid_idx: pending=%b after 5 rows, required 0", fp[1]); end
    for (int r = 5; r < 8; r++) push_row(1, f[r]);
    pulse_done(1);
    exp_next[1] = pack8(f);
    exp_cnt[1]  = 1;
    checks++;
    if (nx[1] !== exp_next[1] || sc[1] !== 8'(exp_cnt[1])) begin
      errors++; $display("FAIL reset_mid_frame: next=%h count=%0d, required %h/%0d", nx[1], sc[1], exp_next[1], exp_cnt[1]);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_restart();
    test_early_sync();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
